// File: rtl/grey_rate_meter.sv
// Gate-time rate meter for the seven grey-coded clock-scaling counters.
// One channel is measured at a time: start sample, wait GATE cycles, end sample, report the delta.
module grey_rate_meter #(
  parameter int GATE        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [41:0] ch_grey,
  input  logic [6:0]  ch_en,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_ch,
  output logic [5:0]  res_delta,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_GATE, S_CAPTURE, S_PRESENT
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [41:0] r_sync [SYNC_STAGES];
  logic [6:0]  r_enQ;
  logic [2:0]  r_curCh;
  logic [5:0]  r_s0;
  logic [5:0]  r_gateCnt;
  logic [5:0]  w_selGrey;
  logic [5:0]  w_selBin;
  logic [3:0]  w_nextAbove;
  logic [3:0]  w_firstEnQ;
  logic [3:0]  w_firstEn;

  // Returns {found, index} of the lowest set bit of mask strictly above cur (cur=-1 means any bit).
  function automatic logic [3:0] lowestAbove(input logic [6:0] mask, input int cur);
    logic [3:0] res;
    res = '0;
    for (int i = 6; i >= 0; i--) begin
      if (mask[i] && (i > cur)) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= ch_grey;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  always_comb begin
    w_selGrey = '0;
    for (int i = 0; i < 7; i++) begin
      if (r_curCh == 3'(i)) w_selGrey = r_sync[SYNC_STAGES-1][6*i +: 6];
    end
    for (int i = 0; i < 6; i++) w_selBin[i] = ^(w_selGrey >> i);
  end

  assign w_nextAbove = lowestAbove(r_enQ, int'(r_curCh));
  assign w_firstEnQ  = lowestAbove(r_enQ, -1);
  assign w_firstEn   = lowestAbove(ch_en, -1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (start && (ch_en != '0)) w_nextState = S_ARM;
      S_ARM:     w_nextState = (GATE > 1) ? S_GATE : S_CAPTURE;
      S_GATE:    if (r_gateCnt == 6'(GATE - 2)) w_nextState = S_CAPTURE;
      S_CAPTURE: w_nextState = S_PRESENT;
      S_PRESENT: begin
        if (res_ready) begin
          if (w_nextAbove[3] || cont) w_nextState = S_ARM;
          else                        w_nextState = S_IDLE;
        end
      end
      default:   w_nextState = S_IDLE;
    endcase
    if (abort) w_nextState = S_IDLE;
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    res_valid = (r_state == S_PRESENT);
  end

  // Datapath follows the FSM; abort freezes it so a discarded result never advances the channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enQ     <= '0;
      r_curCh   <= '0;
      r_s0      <= '0;
      r_gateCnt <= '0;
      res_ch    <= '0;
      res_delta <= '0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start && (ch_en != '0)) begin
            r_enQ   <= ch_en;
            r_curCh <= w_firstEn[2:0];
          end
        end
        S_ARM: begin
          r_s0      <= w_selBin;
          r_gateCnt <= '0;
        end
        S_GATE:    r_gateCnt <= r_gateCnt + 6'd1;
        S_CAPTURE: begin
          res_delta <= w_selBin - r_s0;
          res_ch    <= r_curCh;
        end
        S_PRESENT: begin
          if (res_ready) begin
            if (w_nextAbove[3]) r_curCh <= w_nextAbove[2:0];
            else if (cont)      r_curCh <= w_firstEnQ[2:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grey_rate_meter.sv
// Directed bench for grey_rate_meter: GATE=4 main instance plus a GATE=10 instance for the wrap case.
module tb_grey_rate_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic [41:0] ch_grey;
  logic [6:0]  ch_en;
  logic        start, start10, cont, abort, res_ready, ready10;
  logic        res_valid, busy, valid10, busy10;
  logic [2:0]  res_ch, ch10;
  logic [5:0]  res_delta, delta10;
  logic [5:0]  cnt0, cnt3;
  int          nAsserts = 0;
  int          nFail    = 0;
  int          xferCount = 0;
  int          xferSnap;
  logic        sawValid;

  always #5 clk = ~clk;

  grey_rate_meter #(.GATE(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ch_grey(ch_grey), .ch_en(ch_en), .start(start),
    .cont(cont), .abort(abort), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_delta(res_delta), .busy(busy));

  grey_rate_meter #(.GATE(10), .SYNC_STAGES(3)) dut10 (
    .clk(clk), .rst(rst), .ch_grey(ch_grey), .ch_en(ch_en), .start(start10),
    .cont(1'b0), .abort(1'b0), .res_valid(valid10), .res_ready(ready10),
    .res_ch(ch10), .res_delta(delta10), .busy(busy10));

  function automatic logic [5:0] toGrey(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  // Channel 0 counts +1 per clk, channel 3 counts +8 per clk; all other channels stay static.
  initial begin
    cnt0 = '0;
    cnt3 = '0;
    ch_grey = '0;
    forever begin
      @(negedge clk);
      cnt0 = cnt0 + 6'd1;
      cnt3 = cnt3 + 6'd8;
      ch_grey = '0;
      ch_grey[5:0]   = toGrey(cnt0);
      ch_grey[23:18] = toGrey(cnt3);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (res_valid && res_ready) xferCount++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] en);
    @(negedge clk);
    ch_en = en;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitValid(input int maxCycles);
    int n = 0;
    while (res_valid !== 1'b1 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waitValid", 16'(res_valid), 16'd1);
  endtask

  initial begin
    rst = 1'b1; ch_en = '0; start = 1'b0; start10 = 1'b0; cont = 1'b0;
    abort = 1'b0; res_ready = 1'b0; ready10 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstState", {6'd0, busy, res_valid, 2'd0, res_ch, res_delta[2:0]}, 16'd0);
    checkOutput("rstDelta", 16'(res_delta), 16'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Empty mask must not start a sweep.
    applyStimulus(7'b0000000);
    checkOutput("emptyStartBusy", 16'(busy), 16'd0);

    // Single channel 0, +1 per clk over a 4-cycle gate.
    res_ready = 1'b1;
    applyStimulus(7'b0000001);
    checkOutput("ch0Busy", 16'(busy), 16'd1);
    waitValid(20);
    checkOutput("ch0Ch", 16'(res_ch), 16'd0);
    checkOutput("ch0Delta", 16'(res_delta), 16'd4);
    @(negedge clk);
    checkOutput("ch0ValidDrop", 16'(res_valid), 16'd0);
    checkOutput("ch0Idle", 16'(busy), 16'd0);

    // Sparse mask over static channels.
    applyStimulus(7'b1010010);
    waitValid(20);
    checkOutput("sparseCh1", 16'(res_ch), 16'd1);
    checkOutput("sparseD1", 16'(res_delta), 16'd0);
    @(negedge clk);
    waitValid(20);
    checkOutput("sparseCh4", 16'(res_ch), 16'd4);
    checkOutput("sparseD4", 16'(res_delta), 16'd0);
    @(negedge clk);
    waitValid(20);
    checkOutput("sparseCh6", 16'(res_ch), 16'd6);
    checkOutput("sparseD6", 16'(res_delta), 16'd0);
    @(negedge clk);
    checkOutput("sparseIdle", 16'(busy), 16'd0);

    // Channel 3 at +8 per clk: 32 with GATE=4, 80 mod 64 = 16 with GATE=10.
    @(negedge clk);
    ch_en = 7'b0001000;
    start = 1'b1;
    start10 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start10 = 1'b0;
    waitValid(20);
    checkOutput("ch3Ch", 16'(res_ch), 16'd3);
    checkOutput("ch3Delta", 16'(res_delta), 16'd32);
    begin
      int n = 0;
      while (valid10 !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("g10Valid", 16'(valid10), 16'd1);
    checkOutput("g10Ch", 16'(ch10), 16'd3);
    checkOutput("g10Delta", 16'(delta10), 16'd16);
    ready10 = 1'b1;
    @(negedge clk);
    checkOutput("g10Idle", 16'(busy10), 16'd0);

    // Back-pressure: result must hold for 20 cycles, then exactly one transfer.
    res_ready = 1'b0;
    applyStimulus(7'b0000001);
    waitValid(20);
    xferSnap = xferCount;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("holdResult", {7'd0, res_valid, 2'd0, res_ch, 3'd0}, {7'd0, 1'b1, 2'd0, 3'd0, 3'd0});
      checkOutput("holdDelta", 16'(res_delta), 16'd4);
    end
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("holdOneXfer", 16'(xferCount - xferSnap), 16'd1);
    checkOutput("holdIdle", 16'(busy), 16'd0);

    // Continuous sweep 0,1,0,1 then cont dropped: sweep ends after channel 1.
    cont = 1'b1;
    applyStimulus(7'b0000011);
    for (int i = 0; i < 4; i++) begin
      waitValid(20);
      checkOutput("contCh", 16'(res_ch), 16'(i % 2));
      checkOutput("contDelta", 16'(res_delta), (i % 2 == 0) ? 16'd4 : 16'd0);
      @(negedge clk);
    end
    cont = 1'b0;
    waitValid(20);
    checkOutput("contEndCh0", 16'(res_ch), 16'd0);
    @(negedge clk);
    waitValid(20);
    checkOutput("contEndCh1", 16'(res_ch), 16'd1);
    @(negedge clk);
    checkOutput("contEndIdle", 16'(busy), 16'd0);

    // Abort in GATE: no result may appear afterwards.
    xferSnap = xferCount;
    applyStimulus(7'b0000001);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortIdle", {15'd0, busy}, 16'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) sawValid = 1'b1;
    end
    checkOutput("abortNoResult", 16'(sawValid), 16'd0);
    checkOutput("abortNoXfer", 16'(xferCount - xferSnap), 16'd0);

    // Async reset while a result is pending.
    res_ready = 1'b0;
    applyStimulus(7'b0001000);
    waitValid(20);
    xferSnap = xferCount;
    rst = 1'b1;
    #1;
    checkOutput("rstPresentValid", 16'(res_valid), 16'd0);
    checkOutput("rstPresentBusy", 16'(busy), 16'd0);
    checkOutput("rstPresentDelta", 16'(res_delta), 16'd0);
    res_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstNoXfer", 16'(xferCount - xferSnap), 16'd0);
    applyStimulus(7'b0000001);
    waitValid(20);
    checkOutput("postRstCh", 16'(res_ch), 16'd0);
    checkOutput("postRstDelta", 16'(res_delta), 16'd4);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/grey_rate_meter.md
Name: grey_rate_meter

Overview:
- Measurement scheduler for the seven 6-bit grey-code counters produced by the clock-scaling block. Channel order: grey, m2, m4, m8, d2, d4, d8.
- Shares a single sample/subtract datapath between the channels. For each enabled channel in turn it captures the counter value, waits a fixed gate window of clk cycles, captures the value again, and reports the count delta through a valid/ready result port.
- Sits in the clk domain beside the clock-scaling block. Supports one-shot sweeps or continuous sweeping.

Parameters:
- GATE, 4, gate window in clk cycles between start and end samples; legal range 1..63.
- SYNC_STAGES, 2, synchronizer flops per grey bit; legal range 2..3.

Ports:
- Power pins via the codebase's standard power-in macro.
- clk  in  1  system clock; all logic in this domain.
- rst  in  1  reset, asynchronous, active-high; clears every flop.
- ch_grey  in  42  packed grey inputs; channel i occupies bits [6i+5:6i]; asynchronous to clk except channel 0.
- ch_en  in  7  channel enable mask; latched on an accepted start.
- start  in  1  begins a sweep; honoured only in IDLE.
- cont  in  1  1 = restart the sweep after the last channel; sampled at end of each sweep.
- abort  in  1  synchronous abort to IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_ch  out  3  channel index 0..6 of the result.
- res_delta  out  6  (end_bin - start_bin) mod 64.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Synchronizer
  - Each of the 42 bits passes through SYNC_STAGES flops continuously; no gating.
  - Grey coding makes per-channel sampling safe, with at most ±1 count uncertainty.
- Grey-to-binary conversion
  - b[5]=g[5]; b[i]=b[i+1]^g[i].
  - Applied to the synchronized value of the selected channel through a 7:1 mux.
- States: IDLE, ARM, GATE, CAPTURE, PRESENT.
- IDLE
  - On start=1 with ch_en!=0: latch mask into en_q, set cur_ch to the lowest set bit, go to ARM.
  - start with ch_en==0 is ignored and the block stays in IDLE.
- ARM (1 cycle)
  - s0 <= bin(sync[cur_ch]).
  - Go to GATE if GATE>1, else go to CAPTURE.
- GATE
  - Counter runs GATE-1 cycles, then goes to CAPTURE.
  - The end sample is therefore taken exactly GATE cycles after s0.
- CAPTURE (1 cycle)
  - res_delta <= bin(sync[cur_ch]) - s0, modulo 64 (6-bit wrap, no saturation).
  - res_ch <= cur_ch.
  - Go to PRESENT.
- PRESENT
  - res_valid=1.
  - res_ch and res_delta are held stable until res_valid&&res_ready.
  - On handshake:
    - If en_q has a set bit above cur_ch: move cur_ch to the next set bit and go to ARM.
    - Else if cont=1: move cur_ch to the lowest set bit of en_q and go to ARM.
    - Else go to IDLE.
  - res_valid drops the cycle after the handshake.
  - A handshake takes one cycle minimum; res_ready may be held high.
- Interaction rules
  - start is ignored when not in IDLE.
  - ch_en changes take effect only at the next accepted start.
  - abort=1 in any state: next state is IDLE, res_valid=0 next cycle, the pending result is discarded. abort has priority over the handshake and over start in the same cycle.
- Reset values (rst asserted, at any time including mid-sweep)
  - IDLE; res_valid=0, res_ch=0, res_delta=0, busy=0.
  - s0=0, gate counter=0, en_q=0, cur_ch=0, synchronizers=0.
- Throughput: per channel, GATE+2 cycles plus the ready wait.
- Range limit
  - Deltas wrap when the channel increments ≥64 times in GATE cycles (channel m8 wraps if GATE≥8).
  - This is a documented limit; there is no overflow flag.

Test Plan:
- Channel 0 grey counter stepping once per clk, ch_en=7'b0000001, GATE=4, start pulse, res_ready=1 -> one result: res_ch=0, res_delta=4; busy falls; block returns to IDLE.
- ch_en=7'b1010010, static inputs, res_ready=1 -> results in order res_ch=1,4,6, each res_delta=0, then IDLE.
- Channel 3 stepping 8 per clk (grey-encoded), GATE=4 -> res_delta=32. With GATE=10 -> res_delta=(80 mod 64)=16.
- res_ready held 0 for 20 cycles in PRESENT -> res_valid, res_ch and res_delta stay constant. Raise ready -> exactly one transfer.
- cont=1 with ch_en=7'b0000011 -> ordering 0,1,0,1,… Set cont=0 mid-sweep -> the sweep ends after channel 1.
- abort during GATE, and separately async rst during PRESENT -> IDLE, res_valid=0, no result emitted. A new start after reset produces a correct delta.
